// File: rtl/serial_sub_ctrl.sv
// Bit-serial |a-b| sequencer: one full-subtract cell over N cycles, then an
// optional serial two's-complement pass when the final borrow is set.
module serial_sub_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic         neg
);

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  raw;
    logic          bin;
    logic          seen1;

    logic          d;
    logic          bout;
    logic          nbit;

    // Full-subtract cell on the operand LSBs and the serial negate bit.
    always_comb begin
        d    = sa[0] ^ sb[0] ^ bin;
        bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
        nbit = seen1 ? ~raw[0] : raw[0];
    end

    assign busy = (state == SUB) || (state == NEG);
    assign done = (state == DONE);

    // Raw difference and its negation share one register shifting in from the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            raw   <= '0;
            bin   <= 1'b0;
            seen1 <= 1'b0;
            y     <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    sa  <= {1'b0, sa[N-1:1]};
                    sb  <= {1'b0, sb[N-1:1]};
                    raw <= {d, raw[N-1:1]};
                    bin <= bout;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        seen1 <= 1'b0;
                        if (bout) begin
                            state <= NEG;
                        end else begin
                            state <= DONE;
                            y     <= {d, raw[N-1:1]};
                            neg   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NEG: begin
                    raw   <= {nbit, raw[N-1:1]};
                    seen1 <= seen1 | raw[0];
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                        y     <= {nbit, raw[N-1:1]};
                        neg   <= bin;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: latency/result model checked every
// cycle, plus directed cases with literal expectations.
module tb_serial_sub_ctrl;

    localparam int N   = 4;
    localparam int WIN = 2 * N + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic         neg;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int           mBusyLeft = 0;
    bit           mDone = 1'b0;
    int           mY = 0;
    bit           mNeg = 1'b0;
    int           pY = 0;
    bit           pNeg = 1'b0;

    int  rCyc;
    int  rFirstDone;
    int  rDoneCnt;
    int  rBusyCnt;
    int  rY;
    int  rNeg;
    int  rBusyAfterRst;
    int  rYAfterRst;

    serial_sub_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .neg   (neg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: an accepted op occupies N busy cycles, or 2N when a<b, then one done cycle.
    always @(posedge clk) begin
        if (rst) begin
            mBusyLeft = 0;
            mDone     = 1'b0;
            mY        = 0;
            mNeg      = 1'b0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mBusyLeft > 0) begin
            mBusyLeft--;
            if (mBusyLeft == 0) begin
                mDone = 1'b1;
                mY    = pY;
                mNeg  = pNeg;
            end
        end else if (start) begin
            pNeg      = (int'(a) < int'(b));
            pY        = pNeg ? int'(b) - int'(a) : int'(a) - int'(b);
            mBusyLeft = pNeg ? 2 * N : N;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_busy", int'(busy), int'(mBusyLeft > 0));
            checkOutput("model_done", int'(done), int'(mDone));
            checkOutput("model_y", int'(y), mY);
            checkOutput("model_neg", int'(neg), int'(mNeg));
        end
    end

    // Issue one op and watch a fixed window; optional stray start or reset mid-op.
    task automatic applyStimulus(input int ia, input int ib, input int intCyc,
                                 input int xa, input int xb, input int rstCyc);
        @(negedge clk);
        start = 1'b1;
        a     = N'(ia);
        b     = N'(ib);
        rFirstDone    = 0;
        rDoneCnt      = 0;
        rBusyCnt      = 0;
        rY            = -1;
        rNeg          = -1;
        rBusyAfterRst = -1;
        rYAfterRst    = -1;
        for (int cyc = 1; cyc <= WIN; cyc++) begin
            @(negedge clk);
            rCyc = cyc;
            if (busy) rBusyCnt++;
            if (done) begin
                rDoneCnt++;
                if (rFirstDone == 0) begin
                    rFirstDone = cyc;
                    rY         = int'(y);
                    rNeg       = int'(neg);
                end
            end
            if (rstCyc != 0 && cyc == rstCyc + 1) begin
                rBusyAfterRst = int'(busy);
                rYAfterRst    = int'(y);
            end
            start = 1'b0;
            rst   = 1'b0;
            if (cyc == intCyc) begin
                start = 1'b1;
                a     = N'(xa);
                b     = N'(xb);
            end
            if (cyc == rstCyc) rst = 1'b1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        checkEn = 1'b1;

        // Reset held with start high: nothing may start.
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_busy", int'(busy), 0);
            checkOutput("rst_done", int'(done), 0);
            checkOutput("rst_y", int'(y), 0);
            checkOutput("rst_neg", int'(neg), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_op", int'(busy), 0);

        applyStimulus(9, 3, 0, 0, 0, 0);
        checkOutput("t2_busy_cycles", rBusyCnt, 4);
        checkOutput("t2_done_cycle", rFirstDone, 5);
        checkOutput("t2_y", rY, 6);
        checkOutput("t2_neg", rNeg, 0);

        applyStimulus(3, 9, 0, 0, 0, 0);
        checkOutput("t3_busy_cycles", rBusyCnt, 8);
        checkOutput("t3_done_cycle", rFirstDone, 9);
        checkOutput("t3_y", rY, 6);
        checkOutput("t3_neg", rNeg, 1);

        applyStimulus(7, 7, 0, 0, 0, 0);
        checkOutput("t4_eq_done_cycle", rFirstDone, 5);
        checkOutput("t4_eq_y", rY, 0);
        checkOutput("t4_eq_neg", rNeg, 0);

        applyStimulus(0, 15, 0, 0, 0, 0);
        checkOutput("t4_max_done_cycle", rFirstDone, 9);
        checkOutput("t4_max_y", rY, 15);
        checkOutput("t4_max_neg", rNeg, 1);

        applyStimulus(12, 5, 2, 1, 2, 0);
        checkOutput("t5_y", rY, 7);
        checkOutput("t5_neg", rNeg, 0);
        checkOutput("t5_done_count", rDoneCnt, 1);
        checkOutput("t5_done_cycle", rFirstDone, 5);

        applyStimulus(2, 13, 0, 0, 0, 3);
        checkOutput("t6_busy_after_rst", rBusyAfterRst, 0);
        checkOutput("t6_y_after_rst", rYAfterRst, 0);
        checkOutput("t6_done_count", rDoneCnt, 0);

        applyStimulus(13, 2, 0, 0, 0, 0);
        checkOutput("t6_fresh_done_cycle", rFirstDone, 5);
        checkOutput("t6_fresh_y", rY, 11);
        checkOutput("t6_fresh_neg", rNeg, 0);

        // Randomised traffic: bursts of held start, gaps, stray starts and rare resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            a     = N'($urandom);
            b     = N'($urandom);
            start = (i % 400 < 150) ? 1'b1 : ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2 * N + 3) @(negedge clk);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
